wf_slot_allocator: RTL and testbench
====================================

Name: wf_slot_allocator

Overview:
Owns the 40-entry wavefront-slot vacancy state for the compute unit. It grants free slot IDs to the dispatcher through a request/grant handshake, and returns slots to the pool on wavefront completion (done) or halt. It also supports a multi-cycle flush that returns every slot to the pool. Its vacancy vector feeds the issue/fetch logic that consumes per-slot vacant masks.

Parameters:
NUM_SLOTS, 40, number of wavefront slots (must be 40 in this build)
ID_W, 6, width of a wavefront ID
CNT_W, 6, width of the free-slot counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
alloc_req  in  1  dispatcher requests one slot; held high until alloc_gnt
alloc_gnt  out  1  one-cycle pulse; a slot was allocated this cycle
alloc_wfid  out  6  ID of the granted slot; valid only while alloc_gnt=1
done_valid  in  1  a wavefront completed
done_wfid  in  6  ID of the completed wavefront
halt_valid  in  1  a wavefront halted
halt_wfid  in  6  ID of the halted wavefront
flush_req  in  1  one-cycle pulse; release all slots
flush_busy  out  1  flush in progress
vacant  out  40  bit i = 1 means slot i is free
num_free  out  6  population count of vacant
full  out  1  no free slot (vacant == 0)
err_sticky  out  1  illegal release seen; cleared only by reset

Behaviour:
- Reset values (rst=0, immediate): vacant=all ones, num_free=40, full=0, alloc_gnt=0, alloc_wfid=0, flush_busy=0, err_sticky=0, FSM=IDLE, rr_ptr=0.
- FSM states:
  - IDLE: handshake active.
  - GRANT: one cycle; alloc_gnt=1.
  - FLUSH: walks 8 slots per cycle, so 5 cycles for 40 slots.
- IDLE -> GRANT: when alloc_req=1 and vacant!=0.
  - Selects the lowest-index set bit of the registered vacant vector.
  - Latches it into alloc_wfid and clears that vacant bit at the same edge.
  - alloc_gnt rises the cycle after the request was sampled (1-cycle latency).
- GRANT -> IDLE: unconditional. A held alloc_req is re-evaluated in IDLE, so the maximum grant rate is one per 2 cycles.
- alloc_req with full=1: stay in IDLE; no grant; the request waits.
- Release rules (done/halt):
  - A valid release with ID < 40 sets vacant[ID] at the next edge, in any state.
  - done and halt in the same cycle with different IDs: both apply.
  - done and halt with the same ID: treated as a single release.
- Illegal release: ID >= 40, or the target slot is already vacant. Vacant is unchanged and err_sticky is set.
- Same-cycle release and allocation: allocation selects from the pre-edge vacant vector, so a slot released this cycle is grantable from the next cycle. Release and clear never target the same bit, because a released slot was occupied.
- Flush:
  - flush_req in IDLE or GRANT -> FLUSH, with flush_busy=1 from the next cycle.
  - A grant pulse already in flight completes first; FLUSH is entered after GRANT.
  - Each FLUSH cycle sets vacant bits [8k+7:8k], for k=0..4.
  - After k=4, go to IDLE and deassert flush_busy.
  - alloc_req is not granted while in FLUSH.
  - done/halt releases during FLUSH are legal; a duplicate release of an already-flushed slot sets err_sticky.
  - flush_req while flush_busy=1: ignored.
- num_free and full are combinational from registered vacant (no added latency).
- Reset asserted mid-grant or mid-flush: everything returns to reset values immediately.

Optional Feature:
WF_ALLOC_RR_EN.
- Defined:
  - Selection is round-robin: the first set bit at or above rr_ptr, wrapping 39->0.
  - rr_ptr <= (granted ID + 1) mod 40 on each grant.
  - rr_ptr resets to 0 and is unaffected by flush.
- Undefined: fixed lowest-index priority; no rr_ptr register.

Test Plan:
- Reset, then alloc_req held for 4 grants -> alloc_wfid 0,1,2,3 on alternate cycles; num_free=36; vacant=0xFF_FFFF_FFF0.
- Allocate all 40 -> full=1, num_free=0; further req gets no grant. done_wfid=17 -> next grant alloc_wfid=17 within 2 cycles.
- Illegal releases: done_wfid=45 -> vacant unchanged, err_sticky=1. Separately after reset, done_wfid=3 on a vacant slot -> err_sticky=1.
- Same-cycle release and request:
  - Slots 0-39 used; done_wfid=5 plus halt_wfid=9 in the same cycle -> num_free=2.
  - Held alloc_req then grants 5, then 9.
- With 40 allocated, flush_req -> flush_busy high for 5 cycles; vacant=all ones afterward; an alloc_req held during the flush is granted ID 0 after it ends.
- WF_ALLOC_RR_EN defined:
  - Grant 0, done 0, request -> grant 1 (not 0).
  - Continue to 39; then request -> wrap to 0.

Source files
------------

// File: rtl/wf_slot_allocator.sv
// +----------------------------------------------------------------------------+
// | wf_slot_allocator: 40-entry wavefront slot pool with grant/release/flush.   |
// | Optional WF_ALLOC_RR_EN: round-robin grant selection instead of lowest-ID.  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module wf_slot_allocator #(
  parameter int NUM_SLOTS = 40,
  parameter int ID_W      = 6,
  parameter int CNT_W     = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_req,
  output logic                 alloc_gnt,
  output logic [ID_W-1:0]      alloc_wfid,
  input  logic                 done_valid,
  input  logic [ID_W-1:0]      done_wfid,
  input  logic                 halt_valid,
  input  logic [ID_W-1:0]      halt_wfid,
  input  logic                 flush_req,
  output logic                 flush_busy,
  output logic [NUM_SLOTS-1:0] vacant,
  output logic [CNT_W-1:0]     num_free,
  output logic                 full,
  output logic                 err_sticky
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam int                   FLUSH_CHUNKS = NUM_SLOTS / 8;
  localparam logic [2:0]           LAST_CHUNK   = 3'(FLUSH_CHUNKS - 1);
  localparam logic [ID_W-1:0]      LAST_ID      = ID_W'(NUM_SLOTS - 1);
  localparam logic [NUM_SLOTS-1:0] ONE_HOT0     = NUM_SLOTS'(1);
  localparam logic [NUM_SLOTS-1:0] CHUNK0       = NUM_SLOTS'(8'hFF);

  state_t                 state, state_nxt;
  logic [NUM_SLOTS-1:0]   vacant_nxt;
  logic [ID_W-1:0]        wfid_nxt;
  logic                   err_nxt;
  logic [2:0]             chunk, chunk_nxt;
  logic                   grant_take;

  logic                   done_ok, halt_ok, release_err;
  logic [NUM_SLOTS-1:0]   rel_mask;
  logic [ID_W-1:0]        sel_id;
  logic                   any_vacant;

  // A release is legal only for an in-range slot that is currently occupied.
  always_comb begin
    done_ok     = done_valid && (done_wfid <= LAST_ID) && !vacant[done_wfid];
    halt_ok     = halt_valid && (halt_wfid <= LAST_ID) && !vacant[halt_wfid];
    release_err = (done_valid && !done_ok) || (halt_valid && !halt_ok);
    rel_mask    = '0;
    if (done_ok) rel_mask = rel_mask | (ONE_HOT0 << done_wfid);
    if (halt_ok) rel_mask = rel_mask | (ONE_HOT0 << halt_wfid);
  end

  assign any_vacant = |vacant;

`ifdef WF_ALLOC_RR_EN
  logic [ID_W-1:0] rr_ptr, rr_nxt;
  int              probe;

  // Scan offsets from the top down so the smallest offset from rr_ptr wins.
  always_comb begin
    sel_id = '0;
    probe  = 0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      probe = int'(rr_ptr) + i;
      if (probe >= NUM_SLOTS) probe = probe - NUM_SLOTS;
      if (vacant[ID_W'(probe)]) sel_id = ID_W'(probe);
    end
  end

  always_comb begin
    rr_nxt = rr_ptr;
    if (grant_take) rr_nxt = (sel_id == LAST_ID) ? '0 : sel_id + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rr_ptr <= '0;
    else      rr_ptr <= rr_nxt;
  end
`else
  always_comb begin
    sel_id = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (vacant[i]) sel_id = ID_W'(i);
    end
  end
`endif

  // Releases apply in every state; grant clear and release never hit the same bit.
  always_comb begin
    state_nxt  = state;
    vacant_nxt = vacant | rel_mask;
    wfid_nxt   = alloc_wfid;
    chunk_nxt  = chunk;
    grant_take = 1'b0;
    err_nxt    = err_sticky | release_err;
    case (state)
      ST_IDLE: begin
        if (flush_req) begin
          state_nxt = ST_FLUSH;
          chunk_nxt = '0;
        end else if (alloc_req && any_vacant) begin
          state_nxt  = ST_GRANT;
          wfid_nxt   = sel_id;
          vacant_nxt = vacant_nxt & ~(ONE_HOT0 << sel_id);
          grant_take = 1'b1;
        end
      end
      ST_GRANT: begin
        state_nxt = flush_req ? ST_FLUSH : ST_IDLE;
        chunk_nxt = '0;
      end
      ST_FLUSH: begin
        vacant_nxt = vacant_nxt | (CHUNK0 << {chunk, 3'b000});
        if (chunk == LAST_CHUNK) begin
          state_nxt = ST_IDLE;
          chunk_nxt = '0;
        end else begin
          chunk_nxt = chunk + 3'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      vacant     <= '1;
      alloc_wfid <= '0;
      chunk      <= '0;
      err_sticky <= 1'b0;
    end else begin
      state      <= state_nxt;
      vacant     <= vacant_nxt;
      alloc_wfid <= wfid_nxt;
      chunk      <= chunk_nxt;
      err_sticky <= err_nxt;
    end
  end

  always_comb begin
    num_free = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      num_free = num_free + CNT_W'(vacant[i]);
    end
  end

  assign full       = ~any_vacant;
  assign alloc_gnt  = (state == ST_GRANT);
  assign flush_busy = (state == ST_FLUSH);

endmodule

`default_nettype wire

// File: tb/tb_wf_slot_allocator.sv
// Bench for wf_slot_allocator: per-cycle comparison against a slot-pool model
// plus directed scenarios with literal expectations.
`default_nettype none

module tb_wf_slot_allocator;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alloc_req = 1'b0, done_valid = 1'b0, halt_valid = 1'b0, flush_req = 1'b0;
  logic [5:0]  done_wfid = '0, halt_wfid = '0;
  logic        alloc_gnt, flush_busy, full, err_sticky;
  logic [5:0]  alloc_wfid, num_free;
  logic [39:0] vacant;

  int total = 0;
  int bad   = 0;

  wf_slot_allocator dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_wfid(alloc_wfid),
    .done_valid(done_valid), .done_wfid(done_wfid),
    .halt_valid(halt_valid), .halt_wfid(halt_wfid),
    .flush_req(flush_req), .flush_busy(flush_busy),
    .vacant(vacant), .num_free(num_free), .full(full), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Pool model: occupancy as a bit set, grant pending flag, flush cycles left.
  typedef struct packed {
    logic [39:0] vac;
    logic        gnt;
    logic [5:0]  wfid;
    logic        err;
    int          flush_left;
    int          rr;
  } model_t;

  localparam model_t M_RESET = '{vac: '1, gnt: 1'b0, wfid: '0, err: 1'b0, flush_left: 0, rr: 0};
  model_t m;

  function automatic model_t step(model_t c);
    model_t n = c;
    int pick = -1;
    int base = 0;
    if (done_valid) begin
      if (done_wfid >= 40 || c.vac[done_wfid]) n.err = 1'b1;
      else n.vac[done_wfid] = 1'b1;
    end
    if (halt_valid) begin
      if (halt_wfid >= 40 || c.vac[halt_wfid]) n.err = 1'b1;
      else n.vac[halt_wfid] = 1'b1;
    end
    n.gnt = 1'b0;
    if (c.flush_left > 0) begin
      for (int b = 0; b < 8; b++) n.vac[(5 - c.flush_left) * 8 + b] = 1'b1;
      n.flush_left = c.flush_left - 1;
    end else if (flush_req) begin
      n.flush_left = 5;
    end else if (!c.gnt && alloc_req) begin
`ifdef WF_ALLOC_RR_EN
      base = c.rr;
`endif
      for (int i = 0; i < 40; i++) begin
        int idx = (base + i) % 40;
        if (pick < 0 && c.vac[idx]) pick = idx;
      end
      if (pick >= 0) begin
        n.vac[pick] = 1'b0;
        n.gnt       = 1'b1;
        n.wfid      = 6'(pick);
        n.rr        = (pick + 1) % 40;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m <= M_RESET;
    else      m <= step(m);
  end

  always @(negedge clk) begin
    if (rst) begin
      check("cyc_vacant", vacant, m.vac);
      check("cyc_num_free", num_free, $countones(m.vac));
      check("cyc_full", full, m.vac == 40'd0);
      check("cyc_gnt", alloc_gnt, m.gnt);
      check("cyc_busy", flush_busy, m.flush_left > 0);
      check("cyc_err", err_sticky, m.err);
      if (m.gnt) check("cyc_wfid", alloc_wfid, m.wfid);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input string nm, input int budget, input int exp);
    int got = -1;
    for (int c = 0; c < budget && got < 0; c++) begin
      tick();
      if (alloc_gnt) got = int'(alloc_wfid);
    end
    check(nm, got, exp);
  endtask

  task automatic release_pulse(input bit d, input int did, input bit h, input int hid);
    done_valid = d; done_wfid = 6'(did);
    halt_valid = h; halt_wfid = 6'(hid);
    tick();
    done_valid = 1'b0; halt_valid = 1'b0;
  endtask

  task automatic fill(input string nm, input int from);
    alloc_req = 1'b1;
    for (int i = from; i < 40; i++) wait_gnt(nm, 4, i);
    alloc_req = 1'b0;
  endtask

  initial begin
    int cnt;
    repeat (2) @(posedge clk);
    #1;
    check("rst_vacant", vacant, 40'hFF_FFFF_FFFF);
    check("rst_num_free", num_free, 40);
    check("rst_full", full, 0);
    check("rst_gnt", alloc_gnt, 0);
    check("rst_wfid", alloc_wfid, 0);
    check("rst_busy", flush_busy, 0);
    check("rst_err", err_sticky, 0);
    rst = 1'b1;

    alloc_req = 1'b1;
    for (int i = 0; i < 4; i++) wait_gnt("first4", 2 + (i == 0 ? 1 : 0), i);
    alloc_req = 1'b0;
    check("free36", num_free, 36);
    check("vac36", vacant, 40'hFF_FFFF_FFF0);

    fill("fill", 4);
    tick();
    check("full_flag", full, 1);
    check("full_cnt", num_free, 0);
    alloc_req = 1'b1;
    cnt = 0;
    repeat (6) begin tick(); if (alloc_gnt) cnt++; end
    check("no_gnt_when_full", cnt, 0);
    release_pulse(1, 17, 0, 0);
    wait_gnt("regrant17", 2, 17);
    alloc_req = 1'b0;
    tick();

    release_pulse(1, 45, 0, 0);
    check("illegal_id_err", err_sticky, 1);
    check("illegal_id_vac", vacant, 40'd0);
    rst = 1'b0;
    #1;
    check("async_rst_err", err_sticky, 0);
    check("async_rst_vac", vacant, 40'hFF_FFFF_FFFF);
    tick();
    rst = 1'b1;
    release_pulse(1, 3, 0, 0);
    check("dup_release_err", err_sticky, 1);

    rst = 1'b0; tick(); rst = 1'b1;
    fill("fill2", 0);
    alloc_req = 1'b1;
    release_pulse(1, 5, 1, 9);
    check("dual_release_free", num_free, 2);
    wait_gnt("same_cyc_5", 3, 5);
    wait_gnt("then_9", 3, 9);
    alloc_req = 1'b0;
    tick();

    flush_req = 1'b1; alloc_req = 1'b1;
    tick();
    flush_req = 1'b0;
    cnt = 0;
    for (int c = 0; c < 12 && flush_busy; c++) begin
      cnt++;
      if (cnt == 1) begin done_valid = 1'b1; done_wfid = 6'd39; end
      if (cnt == 2) flush_req = 1'b1;
      if (cnt == 3) begin halt_valid = 1'b1; halt_wfid = 6'd2; end
      tick();
      done_valid = 1'b0; halt_valid = 1'b0; flush_req = 1'b0;
    end
    check("flush_cycles", cnt, 5);
    check("flush_vac", vacant, 40'hFF_FFFF_FFFF);
    check("flush_dup_err", err_sticky, 1);
`ifdef WF_ALLOC_RR_EN
    wait_gnt("post_flush", 4, 10);
`else
    wait_gnt("post_flush", 4, 0);
`endif
    alloc_req = 1'b0;
    tick();

    flush_req = 1'b1; tick(); flush_req = 1'b0; tick();
    check("mid_flush_busy", flush_busy, 1);
    rst = 1'b0;
    #1;
    check("mid_rst_busy", flush_busy, 0);
    check("mid_rst_free", num_free, 40);
    check("mid_rst_err", err_sticky, 0);
    tick();
    rst = 1'b1;

`ifdef WF_ALLOC_RR_EN
    alloc_req = 1'b1; wait_gnt("rr_0", 4, 0); alloc_req = 1'b0; tick();
    release_pulse(1, 0, 0, 0);
    alloc_req = 1'b1;
    wait_gnt("rr_1", 4, 1);
    for (int i = 2; i < 40; i++) wait_gnt("rr_run", 4, i);
    alloc_req = 1'b0; tick();
    release_pulse(1, 39, 0, 0);
    alloc_req = 1'b1;
    wait_gnt("rr_wrap0", 4, 0);
    wait_gnt("rr_39", 4, 39);
    alloc_req = 1'b0; tick();
`endif

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule

`default_nettype wire
